led_port: RTL and testbench
===========================

# led_port

Memory-mapped 5-bit LED output port on the 16-bit CPU data bus, the write-side counterpart of the button input port. The CPU writes one 16-bit control word holding static LED levels, a per-LED blink mask and a blink-rate select. The block drives the LED pins from registered state and toggles blinking LEDs from an internal prescaler. An optional read path returns the control word onto the shared bus.

## Interface
- `PRESCALE_LOG2`, default 10: base blink half-period exponent. Half-period = 2^(PRESCALE_LOG2 + RATE) clk cycles.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_bus`  inout  16  shared CPU data bus. Input for writes; driven only on readback (see Configuration), otherwise `16'bz`.
- `enable`  input  1  chip select for this port, from the address decoder.
- `write`  input  1  bus direction; 1 = CPU write, 0 = CPU read. Meaningful only while `enable`=1.
- `leds`  output  5  LED drive, registered.

## Operation
- Control word `ctrl[12:0]`, written from `data_bus`:
  - `[4:0]` LEVEL: static LED level.
  - `[9:5]` MASK: per-LED blink enable.
  - `[12:10]` RATE: 0–7.
  - `[15:13]` reserved; ignored on write, read back as 0.
- Write strobe: `enable && write`, sampled at the rising edge of `clk`.
- Each edge with the strobe asserted:
  - `ctrl` <= `data_bus[12:0]`.
  - `cnt` <= 0; `phase` <= 0.
- Prescaler `cnt` has width PRESCALE_LOG2+7. While there is no strobe it increments every cycle.
- Terminal count: `cnt == 2^(PRESCALE_LOG2+RATE) - 1`. On that edge `cnt` <= 0 and `phase` toggles.
- LED function, per bit i: `leds[i]` = `MASK[i] ? LEVEL[i] ^ phase : LEVEL[i]`.
- `leds` is registered from next-state `ctrl`/`phase`, so it always equals the function of the current register state.
- The prescaler runs when MASK = 0; `phase` then has no visible effect.
- Holding the strobe for several cycles rewrites `ctrl` on every edge and holds `cnt`/`phase` at 0.

## Timing
- Reset (`reset`=1 at an edge): `ctrl`=0, `cnt`=0, `phase`=0, `leds`=5'b0. `data_bus` = z whenever no readback is in progress.
- Reset has priority over the write strobe and the terminal count. Reset mid-blink clears everything at that edge.
- Write latency: strobe sampled at edge N gives new `leds` valid immediately after edge N (1 edge, no extra pipeline).
- Blink: after a write at edge N, the first toggle happens at edge N + 2^(PRESCALE_LOG2+RATE). Later toggles follow every 2^(PRESCALE_LOG2+RATE) edges. Full LED period is twice that.
- Simultaneous strobe and terminal count: the write wins. `phase`=0, `cnt`=0, no toggle.
- RATE change by a write always restarts from `cnt`=0, `phase`=0. There is never a truncated or overflowed count.
- `enable`=0: `write` ignored, no state change from the bus.

## Configuration
- `LED_PORT_READBACK_EN` defined:
  - `data_bus` = `{3'b0, ctrl[12:0]}` combinationally while `enable && !write`.
  - `data_bus` = `16'bz` otherwise.
- `LED_PORT_READBACK_EN` undefined:
  - `data_bus` is never driven (constant `16'bz`); the port is write-only.
  - CPU reads of this address see a floating bus.
  - The write path and LED behaviour are identical in both builds.

## Test plan
- Reset: hold `reset`=1 for 2 cycles while `enable`=1, `write`=1, `data_bus`=16'hFFFF. Required: `leds`=0 after release, `ctrl`=0, and (with readback) a read returns 16'h0000.
- Static write: write 16'h0015. Required: `leds`=5'b10101 after the same edge, unchanged for 100 cycles.
- Blink (PRESCALE_LOG2=2): write 16'h0021 (LEVEL bit0=1, MASK bit0=1, RATE=0).
  - Required: `leds[0]`=1 for 4 cycles, 0 for 4 cycles, then repeat.
  - Then write RATE=2 (16'h0821): required 16-cycle half-periods starting at `leds[0]`=1.
- Write on terminal-count edge: issue a write of 16'h0021 exactly on the toggle edge. Required: no toggle, `leds[0]`=1, next toggle 4 cycles later.
- Reset mid-blink: assert `reset` while `leds[0]`=0 in the blink phase. Required: `leds`=0 and no further toggling until a new write.
- Readback: write 16'hFFFF, then read (`enable`=1, `write`=0).
  - With `LED_PORT_READBACK_EN`: `data_bus`=16'h1FFF.
  - Without it: `data_bus`=z.
  - `enable`=0 in either build: z.

Source files
------------

// File: rtl/led_port.sv
// led_port: memory-mapped 5-LED output port with per-LED blink and rate select.
// Define LED_PORT_READBACK_EN to return the control word onto data_bus on CPU reads.
module led_port #(
    parameter int PRESCALE_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] data_bus,
    input  logic        enable,
    input  logic        write,
    output logic [4:0]  leds
);

    localparam int CW = PRESCALE_LOG2 + 7;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [12:0]   ctrl_q, ctrl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tc;
    logic          phase_q, phase_d;
    logic [4:0]    leds_d;
    logic          strobe;
    logic          unused_rsvd;

    assign strobe      = enable && write;
    assign unused_rsvd = ^data_bus[15:13];

    // Terminal count for the current rate; RATE=7 wraps the shift to all-ones.
    always_comb begin
        tc = (ONE << (PRESCALE_LOG2 + int'(ctrl_q[12:10]))) - ONE;
    end

    // Next state: a write restarts the prescaler, else count and toggle at terminal.
    always_comb begin
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q + ONE;
        phase_d = phase_q;
        if (strobe) begin
            ctrl_d  = data_bus[12:0];
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == tc) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
        leds_d = ctrl_d[4:0] ^ (ctrl_d[9:5] & {5{phase_d}});
    end

    // State and LED registers; reset overrides writes and terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            leds    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            leds    <= leds_d;
        end
    end

`ifdef LED_PORT_READBACK_EN
    assign data_bus = (enable && !write) ? {3'b000, ctrl_q} : 16'bz;
`else
    assign data_bus = 16'bz;
`endif

endmodule

// File: tb/tb_led_port.sv
// tb_led_port: scoreboard bench for led_port with a short prescaler.
// Undriven bus reads as all-ones through the bench pull-up.
module tb_led_port;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       write = 1'b0;
    logic       drv_en = 1'b0;
    logic [15:0] drv_val = 16'h0;
    logic [4:0] leds;
    tri1  [15:0] data_bus;

    assign data_bus = drv_en ? drv_val : 16'bz;

`ifdef LED_PORT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    led_port #(.PRESCALE_LOG2(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_bus (data_bus),
        .enable   (enable),
        .write    (write),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  leds;
        logic        chk_bus;
        logic [15:0] bus;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t tmp_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expectation per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (leds !== mon_e.leds) begin
                errors++;
                $display("FAIL leds @%0t: got %b want %b", $time, leds, mon_e.leds);
            end
            if (mon_e.chk_bus) begin
                checks++;
                if (data_bus !== mon_e.bus) begin
                    errors++;
                    $display("FAIL bus @%0t: got %h want %h", $time, data_bus, mon_e.bus);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic en, input logic wr, input logic [15:0] v);
        reset   = r;
        enable  = en;
        write   = wr;
        drv_val = v;
        drv_en  = en && wr;
    endtask

    task automatic tick(input logic [4:0] e);
        @(posedge clk);
        #1;
        sb.push_back('{e, 1'b0, 16'h0});
    endtask

    task automatic bus_chk(input logic en, input logic [15:0] eb);
        reset  = 1'b0;
        enable = en;
        write  = 1'b0;
        drv_en = 1'b0;
        tmp_e  = sb.pop_back();
        tmp_e.chk_bus = 1'b1;
        tmp_e.bus     = eb;
        sb.push_back(tmp_e);
    endtask

    initial begin
        // Reset held with a concurrent write strobe
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF);
        tick(5'd0);
        tick(5'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick(5'd0);
        bus_chk(1'b1, RB ? 16'h0000 : 16'hFFFF);
        tick(5'd0);

        // Static level write
        drive(1'b0, 1'b1, 1'b1, 16'h0015);
        tick(5'b10101);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 100; k++) tick(5'b10101);

        // Blink at RATE=0: half-period 4
        drive(1'b0, 1'b1, 1'b1, 16'h0021);
        tick(5'd1);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 16; k++) tick(((k / 4) % 2) ? 5'd0 : 5'd1);

        // RATE=2: half-period 16
        drive(1'b0, 1'b1, 1'b1, 16'h0821);
        tick(5'd1);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 40; k++) tick(((k / 16) % 2) ? 5'd0 : 5'd1);

        // Write landing on the terminal-count edge
        drive(1'b0, 1'b1, 1'b1, 16'h0021);
        tick(5'd1);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 3; k++) tick(5'd1);
        drive(1'b0, 1'b1, 1'b1, 16'h0021);
        tick(5'd1);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 3; k++) tick(5'd1);
        tick(5'd0);
        tick(5'd0);

        // Reset mid-blink while leds[0]=0
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tick(5'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 20; k++) tick(5'd0);

        // Readback of reserved-bit write, then deselected read
        drive(1'b0, 1'b1, 1'b1, 16'hFFFF);
        tick(5'h1F);
        bus_chk(1'b1, RB ? 16'h1FFF : 16'hFFFF);
        tick(5'h1F);
        bus_chk(1'b0, 16'hFFFF);
        tick(5'h1F);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick(5'h1F);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
